// File: rtl/instr_mem_loader.sv
// Instruction memory with a byte-stream program loader and XOR checksum.
// Define INSTR_MEM_BOOT_PROG_EN to preload a small boot program on reset.
module instr_mem_loader #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] A,
  output logic [31:0]       RD,
  input  logic              load_start,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int CW = (ADDR_W > 8 ? ADDR_W : 8) + 1;
  localparam logic [CW-1:0] DEPTH_W = CW'(DEPTH);
  localparam logic [ADDR_W:0] DEPTH_R = (ADDR_W + 1)'(DEPTH);

`ifdef INSTR_MEM_BOOT_PROG_EN
  localparam logic [31:0] BOOT [5] = '{
    32'h200500CA, 32'h00A52020, 32'h00841820,
    32'h00631020, 32'h00420820
  };
`endif

  typedef enum logic [2:0] {
    IDLE, COUNT, DATA, CHECK, FIN
  } state_t;

  state_t      state;
  logic [31:0] mem [DEPTH];
  logic [7:0]  n_words;
  logic [7:0]  wcnt;
  logic [CW-1:0] waddr;
  logic [1:0]  bcnt;
  logic [23:0] shift;
  logic [7:0]  xsum;
  logic        acc;
  logic [7:0]  xnext;

  assign acc   = byte_valid & byte_ready;
  assign xnext = xsum ^ byte_in;

  always_comb begin
    RD = 32'h0;
    if (!busy && ({1'b0, A} < DEPTH_R))
      RD = mem[A];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      byte_ready <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      n_words    <= '0;
      wcnt       <= '0;
      waddr      <= '0;
      bcnt       <= '0;
      shift      <= '0;
      xsum       <= '0;
      for (int i = 0; i < DEPTH; i++) begin
`ifdef INSTR_MEM_BOOT_PROG_EN
        mem[i] <= (i < 5) ? BOOT[i[2:0]] : 32'h0;
`else
        mem[i] <= 32'h0;
`endif
      end
    end else begin
      unique case (state)
        IDLE: begin
          if (load_start) begin
            state      <= COUNT;
            byte_ready <= 1'b1;
            busy       <= 1'b1;
            err        <= 1'b0;
            wcnt       <= '0;
            waddr      <= '0;
            bcnt       <= '0;
            xsum       <= '0;
          end
        end
        COUNT: begin
          if (acc) begin
            n_words <= byte_in;
            xsum    <= xnext;
            state   <= (byte_in == 8'd0) ? CHECK : DATA;
          end
        end
        DATA: begin
          if (acc) begin
            xsum  <= xnext;
            bcnt  <= bcnt + 2'd1;
            shift <= {shift[15:0], byte_in};
            if (bcnt == 2'd3) begin
              // Words past the end are dropped, never wrapped.
              if (waddr < DEPTH_W)
                mem[waddr[ADDR_W-1:0]] <= {shift, byte_in};
              else
                err <= 1'b1;
              waddr <= waddr + 1'b1;
              wcnt  <= wcnt + 8'd1;
              if (wcnt + 8'd1 == n_words)
                state <= CHECK;
            end
          end
        end
        CHECK: begin
          if (acc) begin
            if (byte_in != xsum)
              err <= 1'b1;
            state      <= FIN;
            byte_ready <= 1'b0;
            done       <= 1'b1;
          end
        end
        FIN: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Randomised bench for instr_mem_loader against a word-level load model.
// A second instance with DEPTH=2 exercises the overflow path.
module tb_instr_mem_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [7:0]  A = '0;
  logic        load_start = 1'b0;
  logic [7:0]  byte_in = '0;
  logic        byte_valid = 1'b0;

  logic [31:0] rd, rd2;
  logic        byte_ready, busy, done, err;
  logic        byte_ready2, busy2, done2, err2;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] model_mem [256];
  logic        model_err;
  logic [7:0]  stream [$];

  instr_mem_loader #(.ADDR_W(8), .DEPTH(256)) dut (
    .clk(clk), .rst_n(rst_n), .A(A), .RD(rd),
    .load_start(load_start), .byte_in(byte_in),
    .byte_valid(byte_valid), .byte_ready(byte_ready),
    .busy(busy), .done(done), .err(err)
  );

  instr_mem_loader #(.ADDR_W(8), .DEPTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .A(A), .RD(rd2),
    .load_start(load_start), .byte_in(byte_in),
    .byte_valid(byte_valid), .byte_ready(byte_ready2),
    .busy(busy2), .done(done2), .err(err2)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    for (int i = 0; i < 256; i++) model_mem[i] = 32'h0;
`ifdef INSTR_MEM_BOOT_PROG_EN
    model_mem[0] = 32'h200500CA;
    model_mem[1] = 32'h00A52020;
    model_mem[2] = 32'h00841820;
    model_mem[3] = 32'h00631020;
    model_mem[4] = 32'h00420820;
`endif
  endfunction

  // Checksum is the XOR of N and every data byte.
  function automatic logic [7:0] xor_of(int len);
    logic [7:0] x = 8'h0;
    for (int i = 0; i < len; i++) x ^= stream[i];
    return x;
  endfunction

  function automatic void model_load();
    int n = int'(stream[0]);
    int last = stream.size() - 1;
    model_err = (xor_of(last) != stream[last]);
    for (int w = 0; w < n; w++)
      model_mem[w] = {stream[1+4*w], stream[2+4*w],
                      stream[3+4*w], stream[4+4*w]};
  endfunction

  function automatic void make_stream(int n, bit good);
    logic [7:0] x;
    stream = {};
    stream.push_back(8'(n));
    for (int i = 0; i < 4 * n; i++)
      stream.push_back(8'($urandom_range(0, 255)));
    x = xor_of(stream.size());
    if (!good) x ^= 8'($urandom_range(1, 255));
    stream.push_back(x);
  endfunction

  task automatic send_byte(input logic [7:0] b, input int gap_max,
                           input bit noise);
    int g = (gap_max > 0) ? $urandom_range(0, gap_max) : 0;
    int t = 0;
    repeat (g) begin
      @(negedge clk);
      byte_valid = 1'b0;
      byte_in = 8'($urandom_range(0, 255));
      load_start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    end
    @(negedge clk);
    load_start = 1'b0;
    byte_valid = 1'b1;
    byte_in = b;
    while (!byte_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!byte_ready) begin
      vectors++;
      miscompares++;
      $display("FAIL byte_ready_timeout got 0 exp 1");
    end
    @(posedge clk);
  endtask

  task automatic do_load(input int gap_max, input bit noise);
    @(negedge clk);
    load_start = 1'b1;
    byte_valid = 1'($urandom_range(0, 1));
    byte_in = 8'hFF;
    @(negedge clk);
    load_start = 1'b0;
    byte_valid = 1'b0;
    foreach (stream[i])
      send_byte(stream[i], gap_max,
                noise && i > 0 && i < stream.size() - 1);
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    vectors++;
    if ({busy, byte_ready, done, err} !== 4'b0) begin
      miscompares++;
      $display("FAIL reset_flags got %b exp 0000",
               {busy, byte_ready, done, err});
    end
    for (int a = 0; a < 6; a++) begin
      A = 8'(a);
      #1;
      vectors++;
      if (rd !== model_mem[a]) begin
        miscompares++;
        $display("FAIL reset_rd[%0d] got %h exp %h", a, rd, model_mem[a]);
      end
    end
    A = 8'd2;
    #1;
    vectors++;
    if (rd2 !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_rd2_oob got %h exp 0", rd2);
    end
  endtask

  task automatic test_basic();
    stream = {8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF,
              8'h01, 8'h23, 8'h45, 8'h67, 8'h20};
    model_load();
    do_load(0, 1'b0);
    vectors++;
    if ({done, err} !== 2'b10) begin
      miscompares++;
      $display("FAIL basic_done_err got %b exp 10", {done, err});
    end
    @(negedge clk);
    vectors++;
    if ({done, busy} !== 2'b00) begin
      miscompares++;
      $display("FAIL basic_after_fin got %b exp 00", {done, busy});
    end
    for (int a = 0; a < 3; a++) begin
      A = 8'(a);
      #1;
      vectors++;
      if (rd !== model_mem[a]) begin
        miscompares++;
        $display("FAIL basic_rd[%0d] got %h exp %h", a, rd, model_mem[a]);
      end
    end
  endtask

  task automatic test_bad_checksum();
    stream = {8'h02, 8'h01, 8'h02, 8'h03, 8'h04,
              8'hCA, 8'hFE, 8'hF0, 8'h0D, 8'h00};
    model_load();
    do_load(0, 1'b0);
    vectors++;
    if ({done, err} !== {1'b1, model_err}) begin
      miscompares++;
      $display("FAIL badck_done_err got %b exp 1%b", {done, err}, model_err);
    end
    repeat (4) @(negedge clk);
    vectors++;
    if (err !== 1'b1) begin
      miscompares++;
      $display("FAIL badck_sticky got %b exp 1", err);
    end
    for (int a = 0; a < 2; a++) begin
      A = 8'(a);
      #1;
      vectors++;
      if (rd !== model_mem[a]) begin
        miscompares++;
        $display("FAIL badck_rd[%0d] got %h exp %h", a, rd, model_mem[a]);
      end
    end
    @(negedge clk);
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
    vectors++;
    if ({busy, err} !== 2'b10) begin
      miscompares++;
      $display("FAIL badck_clear got %b exp 10", {busy, err});
    end
    // N=0 load: count byte then checksum only
    send_byte(8'h00, 0, 1'b0);
    send_byte(8'h00, 0, 1'b0);
    @(negedge clk);
    byte_valid = 1'b0;
    vectors++;
    if ({done, err} !== 2'b10) begin
      miscompares++;
      $display("FAIL zero_words got %b exp 10", {done, err});
    end
    @(negedge clk);
  endtask

  task automatic test_overflow();
    stream = {8'h03};
    repeat (12) stream.push_back(8'h11);
    stream.push_back(8'h03);
    model_load();
    do_load(0, 1'b0);
    vectors++;
    if ({done2, err2, err} !== 3'b110) begin
      miscompares++;
      $display("FAIL ovf_flags got %b exp 110", {done2, err2, err});
    end
    @(negedge clk);
    for (int a = 0; a < 3; a++) begin
      A = 8'(a);
      #1;
      vectors++;
      if (rd2 !== ((a < 2) ? 32'h11111111 : 32'h0)) begin
        miscompares++;
        $display("FAIL ovf_rd2[%0d] got %h", a, rd2);
      end
    end
    make_stream(3, 1'b1);
    model_load();
    do_load(1, 1'b0);
    vectors++;
    if ({done2, err2, err} !== 3'b110) begin
      miscompares++;
      $display("FAIL ovf2_flags got %b exp 110", {done2, err2, err});
    end
    @(negedge clk);
    for (int a = 0; a < 2; a++) begin
      A = 8'(a);
      #1;
      vectors++;
      if (rd2 !== model_mem[a]) begin
        miscompares++;
        $display("FAIL ovf2_rd2[%0d] got %h exp %h", a, rd2, model_mem[a]);
      end
    end
  endtask

  task automatic test_gaps();
    stream = {8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF,
              8'h01, 8'h23, 8'h45, 8'h67, 8'h20};
    model_load();
    do_load(5, 1'b1);
    A = 8'd0;
    #1;
    vectors++;
    if ({done, err, rd} !== {2'b10, 32'h0}) begin
      miscompares++;
      $display("FAIL gaps_fin got %b %h exp 10 00000000", {done, err}, rd);
    end
    @(negedge clk);
    vectors++;
    if (done !== 1'b0) begin
      miscompares++;
      $display("FAIL gaps_done_pulse got %b exp 0", done);
    end
    for (int a = 0; a < 2; a++) begin
      A = 8'(a);
      #1;
      vectors++;
      if (rd !== model_mem[a]) begin
        miscompares++;
        $display("FAIL gaps_rd[%0d] got %h exp %h", a, rd, model_mem[a]);
      end
    end
  endtask

  task automatic test_random();
    repeat (8) begin
      make_stream($urandom_range(0, 5), $urandom_range(0, 3) != 0);
      model_load();
      do_load(2, 1'b1);
      vectors++;
      if ({done, err} !== {1'b1, model_err}) begin
        miscompares++;
        $display("FAIL rand_done_err got %b exp 1%b", {done, err}, model_err);
      end
      @(negedge clk);
      for (int a = 0; a < 6; a++) begin
        A = 8'(a);
        #1;
        vectors++;
        if (rd !== model_mem[a]) begin
          miscompares++;
          $display("FAIL rand_rd[%0d] got %h exp %h", a, rd, model_mem[a]);
        end
      end
    end
  endtask

  task automatic test_reset_midload();
    stream = {8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01};
    @(negedge clk);
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
    foreach (stream[i]) send_byte(stream[i], 0, 1'b0);
    @(negedge clk);
    byte_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({busy, byte_ready, done, err} !== 4'b0) begin
      miscompares++;
      $display("FAIL midrst_flags got %b exp 0000",
               {busy, byte_ready, done, err});
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int a = 0; a < 2; a++) begin
      A = 8'(a);
      #1;
      vectors++;
      if (rd !== model_mem[a]) begin
        miscompares++;
        $display("FAIL midrst_rd[%0d] got %h exp %h", a, rd, model_mem[a]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bad_checksum();
    test_overflow();
    test_gaps();
    test_random();
    test_reset_midload();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
